// File: rtl/dnn_result_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnn_pkg
// Description : Shared types and constants for the inference-engine result
//               reader: score width, class index width, score/index types and
//               the reader FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dnn_pkg;

    localparam int DATA_WIDTH = 8;   // width of one signed class score
    localparam int ADDR_WIDTH = 4;   // width of the class selector / index

    typedef logic signed [DATA_WIDTH-1:0] score_t;
    typedef logic        [ADDR_WIDTH-1:0] class_idx_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_ENG = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        SCAN    = 3'd4
    } rdr_state_e;

endpackage
`default_nettype wire

// File: rtl/dnn_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : dnn_result_reader_if
// Description : Bundles the reader's request/result signals and the engine
//               handshake/selector signals.
//   master : the reader (drives busy, eng_reset, eng_start, out_idx and the
//            result outputs; receives req, eng_done, eng_out)
//   slave  : the surrounding system / engine wrapper
// Revision    : 1.0 - initial release
// ============================================================================
interface dnn_result_reader_if #(
    parameter int DATA_WIDTH = dnn_pkg::DATA_WIDTH,
    parameter int IDX_WIDTH  = dnn_pkg::ADDR_WIDTH
);
    logic                         req;
    logic                         busy;
    logic                         eng_reset;
    logic                         eng_start;
    logic                         eng_done;
    logic        [IDX_WIDTH-1:0]  out_idx;
    logic signed [DATA_WIDTH-1:0] eng_out;
    logic        [IDX_WIDTH-1:0]  class_idx;
    logic signed [DATA_WIDTH-1:0] class_score;
    logic                         result_valid;
    logic                         timeout;

    modport master (
        input  req, eng_done, eng_out,
        output busy, eng_reset, eng_start, out_idx,
               class_idx, class_score, result_valid, timeout
    );

    modport slave (
        output req, eng_done, eng_out,
        input  busy, eng_reset, eng_start, out_idx,
               class_idx, class_score, result_valid, timeout
    );
endinterface
`default_nettype wire

// File: rtl/dnn_result_reader_argmax_acc.sv
`default_nettype none
// ============================================================================
// Module      : argmax_acc
// Description : Running signed maximum with index. When en is high the
//               candidate (idx,val) is folded in: clear loads it
//               unconditionally, otherwise it replaces the held maximum only
//               if strictly greater, so ties keep the earliest index.
//   Ports: clk, rst; clear, en, idx, val in; max_idx, max_val out.
//   max_idx/max_val already include the current candidate, so the caller can
//   capture the final result in the same cycle as the last element.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 4
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         clear,
    input  wire logic                         en,
    input  wire logic        [IDX_WIDTH-1:0]  idx,
    input  wire logic signed [DATA_WIDTH-1:0] val,
    output logic             [IDX_WIDTH-1:0]  max_idx,
    output logic signed      [DATA_WIDTH-1:0] max_val
);
    logic signed [DATA_WIDTH-1:0] max_val_q, max_val_d;
    logic        [IDX_WIDTH-1:0]  max_idx_q, max_idx_d;

    always_comb begin
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (en && (clear || (val > max_val_q))) begin
            max_val_d = val;
            max_idx_d = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_idx = max_idx_d;
    assign max_val = max_val_d;
endmodule
`default_nettype wire

// File: rtl/dnn_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : dnn_result_reader
// Description : Sequences the inference engine (reset pulse, start pulse,
//               wait for done with timeout), then sweeps out_idx over all
//               class scores and publishes the signed argmax.
//   Ports: clk, rst (synchronous, active high); bus (master modport) carrying
//   req/busy, eng_reset/eng_start/eng_done, out_idx/eng_out and the
//   class_idx/class_score/result_valid/timeout results.
// Revision    : 1.0 - initial release
// ============================================================================
module dnn_result_reader #(
    parameter int DATA_WIDTH     = dnn_pkg::DATA_WIDTH,
    parameter int NUM_CLASSES    = 10,
    parameter int IDX_WIDTH      = dnn_pkg::ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 1048575
) (
    input wire logic             clk,
    input wire logic             rst,
    dnn_result_reader_if.master  bus
);
    import dnn_pkg::*;

    localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_WIDTH-1:0]  TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_CLASSES - 1);

    rdr_state_e                   state_q, state_d;
    logic        [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
    logic        [IDX_WIDTH-1:0]  scan_cnt_q, scan_cnt_d;
    logic                         result_valid_q, result_valid_d;
    logic                         timeout_q, timeout_d;
    logic        [IDX_WIDTH-1:0]  class_idx_q, class_idx_d;
    logic signed [DATA_WIDTH-1:0] class_score_q, class_score_d;

    logic                         w_busy, w_eng_reset, w_eng_start, w_acc_en;
    logic        [IDX_WIDTH-1:0]  w_out_idx, w_max_idx;
    logic signed [DATA_WIDTH-1:0] w_max_val;

    argmax_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .clear   (scan_cnt_q == '0),
        .en      (w_acc_en),
        .idx     (scan_cnt_q),
        .val     (bus.eng_out),
        .max_idx (w_max_idx),
        .max_val (w_max_val)
    );

    always_comb begin
        state_d        = state_q;
        to_cnt_d       = to_cnt_q;
        scan_cnt_d     = scan_cnt_q;
        result_valid_d = result_valid_q;
        timeout_d      = timeout_q;
        class_idx_d    = class_idx_q;
        class_score_d  = class_score_q;
        w_busy         = 1'b1;
        w_eng_reset    = 1'b0;
        w_eng_start    = 1'b0;
        w_acc_en       = 1'b0;
        w_out_idx      = '0;
        case (state_q)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.req) begin
                    result_valid_d = 1'b0;
                    timeout_d      = 1'b0;
                    state_d        = RST_ENG;
                end
            end
            RST_ENG: begin
                // Clearing the engine first guarantees a stale done is gone
                // before the start pulse.
                w_eng_reset = 1'b1;
                state_d     = START;
            end
            START: begin
                w_eng_start = 1'b1;
                to_cnt_d    = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                // done takes precedence even on the final permitted cycle.
                if (bus.eng_done) begin
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end
            SCAN: begin
                w_out_idx = scan_cnt_q;
                w_acc_en  = 1'b1;
                if (scan_cnt_q == IDX_LAST) begin
                    class_idx_d    = w_max_idx;
                    class_score_d  = w_max_val;
                    result_valid_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    scan_cnt_d = scan_cnt_q + IDX_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            to_cnt_q       <= '0;
            scan_cnt_q     <= '0;
            result_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            class_idx_q    <= '0;
            class_score_q  <= '0;
        end else begin
            state_q        <= state_d;
            to_cnt_q       <= to_cnt_d;
            scan_cnt_q     <= scan_cnt_d;
            result_valid_q <= result_valid_d;
            timeout_q      <= timeout_d;
            class_idx_q    <= class_idx_d;
            class_score_q  <= class_score_d;
        end
    end

    assign bus.busy         = w_busy;
    assign bus.eng_reset    = w_eng_reset;
    assign bus.eng_start    = w_eng_start;
    assign bus.out_idx      = w_out_idx;
    assign bus.class_idx    = class_idx_q;
    assign bus.class_score  = class_score_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timeout      = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_dnn_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dnn_result_reader
// Description : Self-checking bench for dnn_result_reader. A timeline model
//               predicts every output each cycle from the request cycle, the
//               engine latency and the argmax of the score table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dnn_result_reader;
    import dnn_pkg::*;

    localparam int NC = 10;
    localparam int DW = 8;
    localparam int IW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dnn_result_reader_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dif ();

    dnn_result_reader #(
        .DATA_WIDTH     (DW),
        .NUM_CLASSES    (NC),
        .IDX_WIDTH      (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.master)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- engine model ----------------
    logic signed [DW-1:0] scores [NC];
    logic req_r      = 1'b0;
    logic eng_done_r = 1'b0;
    int   eng_lat    = 1;
    bit   eng_never  = 1'b0;
    int   rem        = 0;

    assign dif.req      = req_r;
    assign dif.eng_done = eng_done_r;
    assign dif.eng_out  = (dif.out_idx < IW'(NC)) ? scores[dif.out_idx] : 8'sd0;

    // done rises eng_lat cycles after the start pulse cycle, stays high.
    always @(posedge clk) begin
        if (dif.eng_reset) begin
            eng_done_r <= 1'b0;
            rem        <= 0;
        end else if (dif.eng_start) begin
            if (!eng_never) begin
                if (eng_lat == 1) eng_done_r <= 1'b1;
                else              rem        <= eng_lat - 1;
            end
        end else if (rem > 0) begin
            rem <= rem - 1;
            if (rem == 1) eng_done_r <= 1'b1;
        end
    end

    // ---------------- timeline model ----------------
    bit r_active = 1'b0;
    bit r_ok;
    int r_t_req, r_w, r_end, r_idx, r_score;
    int h_valid = 0, h_to = 0, h_idx = 0, h_score = 0;
    int t_rst = -1;

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Applies a sampled reset and retires a finished run into the held results.
    function automatic void settle(input int c);
        if (t_rst >= 0 && c > t_rst) begin
            r_active = 1'b0;
            h_valid = 0; h_to = 0; h_idx = 0; h_score = 0;
            t_rst = -1;
        end
        if (r_active && c >= r_end) begin
            h_valid = r_ok ? 1 : 0;
            h_to    = r_ok ? 0 : 1;
            if (r_ok) begin
                h_idx   = r_idx;
                h_score = r_score;
            end
            r_active = 1'b0;
        end
    endfunction

    function automatic void ref_argmax(output int idx, output int sc);
        idx = 0;
        sc  = scores[0];
        for (int i = 1; i < NC; i++)
            if (scores[i] > sc) begin
                idx = i;
                sc  = scores[i];
            end
    endfunction

    always @(negedge clk) begin : checker_blk
        int e_busy, e_rst, e_start, e_oidx, e_valid, e_to, e_idx, e_sc;
        if (cyc >= 1) begin
            settle(cyc);
            e_busy = 0; e_rst = 0; e_start = 0; e_oidx = 0;
            e_valid = h_valid; e_to = h_to; e_idx = h_idx; e_sc = h_score;
            if (r_active && cyc > r_t_req) begin
                e_busy  = 1;
                e_valid = 0;
                e_to    = 0;
                e_rst   = (cyc == r_t_req + 1) ? 1 : 0;
                e_start = (cyc == r_t_req + 2) ? 1 : 0;
                if (r_ok && cyc > r_w) e_oidx = cyc - r_w - 1;
            end
            chk("busy",         dif.busy,         e_busy);
            chk("eng_reset",    dif.eng_reset,    e_rst);
            chk("eng_start",    dif.eng_start,    e_start);
            chk("out_idx",      dif.out_idx,      e_oidx);
            chk("result_valid", dif.result_valid, e_valid);
            chk("timeout",      dif.timeout,      e_to);
            chk("class_idx",    dif.class_idx,    e_idx);
            chk("class_score",  dif.class_score,  e_sc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_run(input int lat, input bit never);
        settle(cyc);
        eng_lat   = lat;
        eng_never = never;
        r_t_req   = cyc;
        r_ok      = !never;
        r_w       = cyc + 2 + lat;
        r_end     = never ? (cyc + 3 + TO) : (r_w + NC + 1);
        ref_argmax(r_idx, r_score);
        r_active  = 1'b1;
        req_r     = 1'b1;
        @(negedge clk);
        req_r     = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int g = 0;
        while (cyc < target && g < 1000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic rand_scores();
        for (int i = 0; i < NC; i++) scores[i] = DW'($urandom);
    endtask

    initial begin
        int first_done, lat, tgt, got;
        bit nv;
        for (int i = 0; i < NC; i++) scores[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy",  dif.busy,         0);
        chk("reset_valid", dif.result_valid, 0);
        chk("reset_idx",   dif.class_idx,    0);

        // Distinct maximum at index 2, latency measured against done.
        scores = '{-8'sd5, 8'sd3, 8'sd7, 8'sd1, 8'sd0, -8'sd128, 8'sd2, 8'sd6, 8'sd6, 8'sd4};
        do_run(5, 1'b0);
        first_done = -1;
        got = 0;
        for (int k = 0; k < 60; k++) begin
            if (first_done < 0 && cyc >= r_t_req + 3 && dif.eng_done) first_done = cyc;
            if (dif.result_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("distinct_valid_seen", got, 1);
        chk("distinct_latency", cyc - first_done, 11);
        chk("distinct_idx",   dif.class_idx,   2);
        chk("distinct_score", dif.class_score, 7);
        wait_cyc(r_end);

        // All equal negatives: lowest index wins.
        for (int i = 0; i < NC; i++) scores[i] = -8'sd3;
        do_run(3, 1'b0);
        wait_cyc(r_end);
        chk("tie_neg_idx",   dif.class_idx,   0);
        chk("tie_neg_score", dif.class_score, -3);

        // 127 at indices 4 and 9; done arrives on the last permitted WAIT cycle.
        for (int i = 0; i < NC; i++) scores[i] = DW'($urandom_range(0, 254)) - 8'sd128;
        scores[4] = 8'sd127;
        scores[9] = 8'sd127;
        do_run(TO, 1'b0);
        wait_cyc(r_end);
        chk("tie_max_idx",   dif.class_idx,   4);
        chk("tie_max_score", dif.class_score, 127);

        // Timeout, then a new request clears it.
        do_run(1, 1'b1);
        wait_cyc(r_end);
        chk("to_flag",  dif.timeout,      1);
        chk("to_busy",  dif.busy,         0);
        chk("to_valid", dif.result_valid, 0);
        chk("to_held_idx", dif.class_idx, 4);
        rand_scores();
        do_run(2, 1'b0);
        chk("to_cleared", dif.timeout, 0);
        wait_cyc(r_end);

        // Request during SCAN is dropped.
        rand_scores();
        do_run(2, 1'b0);
        wait_cyc(r_w + 3);
        req_r = 1'b1;
        @(negedge clk);
        req_r = 1'b0;
        wait_cyc(r_end);

        // Reset at scan index 5, then a fresh run.
        rand_scores();
        do_run(4, 1'b0);
        wait_cyc(r_w + 6);
        chk("pre_rst_out_idx", dif.out_idx, 5);
        rst = 1'b1;
        t_rst = cyc;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",  dif.busy,         0);
        chk("rst_valid", dif.result_valid, 0);
        chk("rst_idx",   dif.class_idx,    0);
        chk("rst_score", dif.class_score,  0);
        rand_scores();
        do_run(6, 1'b0);
        wait_cyc(r_end);

        // req and rst together: reset wins.
        req_r = 1'b1;
        rst   = 1'b1;
        t_rst = cyc;
        @(negedge clk);
        req_r = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("req_rst_busy", dif.busy, 0);

        // Back-to-back runs with different scores.
        scores = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9, 8'sd10};
        do_run(2, 1'b0);
        wait_cyc(r_end);
        scores = '{8'sd50, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9, 8'sd10};
        do_run(3, 1'b0);
        chk("b2b_valid_drop", dif.result_valid, 0);
        chk("b2b_held_idx",   dif.class_idx,    9);
        wait_cyc(r_end);
        chk("b2b_new_idx",   dif.class_idx,   0);
        chk("b2b_new_score", dif.class_score, 50);

        // Randomised runs with stray requests while busy.
        for (int n = 0; n < 15; n++) begin
            rand_scores();
            nv  = ($urandom_range(0, 5) == 0);
            lat = $urandom_range(1, TO);
            do_run(lat, nv);
            if ($urandom_range(0, 1) == 1) begin
                tgt = $urandom_range(r_t_req + 1, r_end - 1);
                wait_cyc(tgt);
                req_r = 1'b1;
                @(negedge clk);
                req_r = 1'b0;
            end
            wait_cyc(r_end);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
